register_file_param: RTL
========================

REGISTER_FILE_PARAM -- requirements
Module: register_file_param

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16: register width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 3: address width; register count NREG = 2**ADDR_W (local, derived).
REQ-003 Port clk SHALL be: input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 Port rst_n SHALL be: input, 1 bit, asynchronous active-low reset.
REQ-005 Port we SHALL be: input, 1 bit, write enable.
REQ-006 Port wa SHALL be: input, ADDR_W bits, write address.
REQ-007 Port wd SHALL be: input, DATA_W bits, write data.
REQ-008 Port ra1 SHALL be: input, ADDR_W bits, read address for port 1.
REQ-009 Port ra2 SHALL be: input, ADDR_W bits, read address for port 2.
REQ-010 Port rd1 SHALL be: output, DATA_W bits, read data for port 1.
REQ-011 Port rd2 SHALL be: output, DATA_W bits, read data for port 2.
REQ-012 Port clr_req SHALL be: input, 1 bit, request to clear all registers.
REQ-013 Port clr_busy SHALL be: output, 1 bit, clear sequence in progress.
REQ-014 Port clr_done SHALL be: output, 1 bit, one-cycle pulse marking clear completion.
REQ-015 Port dbg_regs SHALL be: output, NREG*DATA_W bits, all registers flattened; register i occupies bits [i*DATA_W +: DATA_W].

Function
REQ-016 Writes SHALL be synchronous: on a clk rising edge with we=1 and FSM in IDLE, register[wa] <= wd.
REQ-017 Reads SHALL be combinational: rd1=register[ra1], rd2=register[ra2], zero-cycle latency, both ports independent, including ra1==ra2.
REQ-018 dbg_regs SHALL reflect current register contents combinationally.
REQ-019 The clear FSM SHALL have states IDLE, CLEAR, DONE.
REQ-020 IDLE->CLEAR SHALL occur on a rising edge with clr_req=1; a clear counter loads 0.
REQ-021 In CLEAR, each cycle SHALL write zero to register[counter] and then increment the counter; after register NREG-1 is written, the FSM goes to DONE.
REQ-022 DONE SHALL last exactly one cycle and then return to IDLE.
REQ-023 clr_busy SHALL be 1 exactly in CLEAR; clr_done SHALL be 1 exactly in DONE.
REQ-024 A full clear SHALL take NREG cycles in CLEAR; clr_done SHALL be high in cycle NREG+1 after the edge that samples clr_req.
REQ-025 we SHALL be ignored in CLEAR and DONE; no write is performed and none is queued.
REQ-026 clr_req SHALL be ignored in CLEAR and DONE; clr_req held high in DONE SHALL start a new clear from the following IDLE cycle.
REQ-027 we=1 and clr_req=1 in the same IDLE cycle: the write SHALL complete on that edge, and the clear SHALL start on the same edge.
REQ-028 Reads during CLEAR SHALL return current contents: already-cleared registers read 0, the rest keep their values.
REQ-029 The counter SHALL be ADDR_W bits wide, and its final value NREG-1 SHALL NOT wrap into an extra write.

Reset
REQ-030 With rst_n=0, all registers SHALL go to 0 immediately without a clock, the FSM to IDLE, the counter to 0, and clr_busy and clr_done to 0.
REQ-031 Reset asserted mid-CLEAR SHALL abort the sequence; no clr_done pulse SHALL be produced.
REQ-032 Release of rst_n SHALL be the only reset input; there SHALL be no synchronous reset.

Configuration
REQ-033 Macro RF_BYPASS_EN defined: when the FSM is in IDLE, we=1 and ra1==wa (or ra2==wa), the block SHALL forward wd to rd1 (or rd2) in the same cycle.
REQ-034 Macro RF_BYPASS_EN undefined: rd1 and rd2 SHALL return the pre-write value until after the edge.
REQ-035 The macro SHALL NOT affect dbg_regs, which always shows stored contents.

Verification
REQ-036 Reset, then write reg3=0x1234, reg5=0xABCD, read ra1=3, ra2=5 -> rd1=0x1234, rd2=0xABCD.
REQ-037 Bypass: in one cycle set we=1, wa=2, wd=0x00FF, ra1=2 -> rd1=0x00FF with RF_BYPASS_EN, previous value (0) without it.
REQ-038 Fill all 8 registers with 0xFFFF, pulse clr_req -> clr_busy high for 8 cycles, clr_done pulses in cycle 9, all dbg_regs=0.
REQ-039 During CLEAR, drive we=1, wa=7, wd=0x5555 -> reg7 ends at 0 and no late write occurs.
REQ-040 Assert rst_n=0 at the 4th CLEAR cycle with registers holding 0x0F0F -> all registers 0 immediately, clr_busy=0, clr_done never pulses.
REQ-041 Same cycle: we=1, wa=1, wd=0x7777 and clr_req=1 -> reg1 reads 0x7777 during the first CLEAR cycle and reads 0 after clr_done.

Source files
------------

// File: rtl/register_file_param.sv
// Parameterised register file: one write port, two combinational read ports, and a
// sequential clear-all FSM. Define RF_BYPASS_EN to forward write data to matching read ports.
module register_file_param #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 3
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           we,
    input  logic [ADDR_W-1:0]              wa,
    input  logic [DATA_W-1:0]              wd,
    input  logic [ADDR_W-1:0]              ra1,
    input  logic [ADDR_W-1:0]              ra2,
    output logic [DATA_W-1:0]              rd1,
    output logic [DATA_W-1:0]              rd2,
    input  logic                           clr_req,
    output logic                           clr_busy,
    output logic                           clr_done,
    output logic [(2**ADDR_W)*DATA_W-1:0]  dbg_regs
);

    localparam int unsigned NREG = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREG - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [DATA_W-1:0]   regs_q [NREG];

    logic                wr_en_c;
    logic [ADDR_W-1:0]   wr_addr_c;
    logic [DATA_W-1:0]   wr_data_c;

    // State, clear counter and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next state and the single write-port mux shared by user writes and the clear sweep.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_en_c   = 1'b0;
        wr_addr_c = wa;
        wr_data_c = wd;

        case (state_q)
            ST_IDLE: begin
                wr_en_c = we;
                if (clr_req) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            ST_CLEAR: begin
                wr_en_c   = 1'b1;
                wr_addr_c = cnt_q;
                wr_data_c = '0;
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Status flops track the state being entered so they align with the state register.
        busy_d = (state_d == ST_CLEAR);
        done_d = (state_d == ST_DONE);
    end

    // Register storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en_c) begin
            regs_q[wr_addr_c] <= wr_data_c;
        end
    end

    assign clr_busy = busy_q;
    assign clr_done = done_q;

    // Combinational read ports.
    always_comb begin
        rd1 = regs_q[ra1];
        rd2 = regs_q[ra2];
`ifdef RF_BYPASS_EN
        if ((state_q == ST_IDLE) && we && (ra1 == wa)) begin
            rd1 = wd;
        end
        if ((state_q == ST_IDLE) && we && (ra2 == wa)) begin
            rd2 = wd;
        end
`endif
    end

    for (genvar g = 0; g < int'(NREG); g++) begin : g_dbg
        assign dbg_regs[g*DATA_W +: DATA_W] = regs_q[g];
    end

endmodule
